// File: rtl/tri_bus_arbiter.sv
// Round-robin owner arbiter for a shared (resolved) bus with tenure-limited ownership.
// Optional macro TRI_BUS_ARBITER_TURNAROUND_EN inserts one undriven cycle between owners.
module tri_bus_arbiter #(
    parameter int NREQ       = 4,
    parameter int DW         = 8,
    parameter int MAX_TENURE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           oe,
    output logic [DW-1:0]             bus_data,
    output logic                      bus_valid,
    output logic [$clog2(NREQ)-1:0]   owner_id,
    output logic                      preempt,
    output logic [1:0]                dbg_state_o
);
    localparam int IW = $clog2(NREQ);

`ifdef TRI_BUS_ARBITER_TURNAROUND_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1, S_TURN = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_OWN = 2'd1} state_t;
`endif

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [7:0]        tenure_q, tenure_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              preempt_q, preempt_d;

    logic [IW-1:0]     owner;
    logic [IW-1:0]     next_ptr;
    logic              owner_req;
    logic              expire;

    // Lowest offset from ptr wins; the loop runs high-to-low so the last hit is the winner.
    function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] mask,
                                                input logic [IW-1:0]   ptr);
        logic [NREQ-1:0] g;
        int              idx;
        g = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (mask[idx]) begin
                g      = '0;
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        owner    = '0;
        bus_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner    = IW'(i);
                bus_data = wdata[i*DW +: DW];
            end
        end
    end

    assign next_ptr    = IW'((int'(owner) + 1) % NREQ);
    assign owner_req   = req[owner];
    assign expire      = (tenure_q == 8'(MAX_TENURE)) && (|(req & ~gnt_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            tenure_q  <= '0;
            rr_ptr_q  <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            tenure_q  <= tenure_d;
            rr_ptr_q  <= rr_ptr_d;
            preempt_q <= preempt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        tenure_d  = tenure_q;
        rr_ptr_d  = rr_ptr_q;
        preempt_d = 1'b0;
        case (state_q)
            S_OWN: begin
                if (!owner_req || expire) begin
                    // Preempt only when the owner still wanted the bus.
                    rr_ptr_d  = next_ptr;
                    preempt_d = owner_req;
                    gnt_d     = '0;
                    tenure_d  = '0;
`ifdef TRI_BUS_ARBITER_TURNAROUND_EN
                    state_d   = S_TURN;
`else
                    gnt_d     = rr_pick(req & ~gnt_q, next_ptr);
                    if (|gnt_d) begin
                        state_d  = S_OWN;
                        tenure_d = 8'd1;
                    end else begin
                        state_d  = S_IDLE;
                    end
`endif
                end else if (tenure_q != 8'(MAX_TENURE)) begin
                    tenure_d = tenure_q + 8'd1;
                end
            end
            default: begin
                gnt_d = rr_pick(req, rr_ptr_q);
                if (|req) begin
                    state_d  = S_OWN;
                    tenure_d = 8'd1;
                end else begin
                    state_d  = S_IDLE;
                    tenure_d = '0;
                end
            end
        endcase
    end

    assign gnt         = gnt_q;
    assign oe          = gnt_q;
    assign bus_valid   = |gnt_q;
    assign owner_id    = owner;
    assign preempt     = preempt_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (NREQ=4, DW=8, MAX_TENURE=8) with a running invariant monitor.
module tb_tri_bus_arbiter;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  oe;
    logic [7:0]  bus_data;
    logic        bus_valid;
    logic [1:0]  owner_id;
    logic        preempt;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    tri_bus_arbiter #(.NREQ(4), .DW(8), .MAX_TENURE(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wdata      (wdata),
        .gnt        (gnt),
        .oe         (oe),
        .bus_data   (bus_data),
        .bus_valid  (bus_valid),
        .owner_id   (owner_id),
        .preempt    (preempt),
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] slice(input int i);
        logic [31:0] w;
        w = 32'hD3C2B1A0;
        return w[i*8 +: 8];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("onehot0", 32'($onehot0(gnt)), 32'd1);
            check("oe_eq_gnt", 32'(oe), 32'(gnt));
            if (!bus_valid) check("idle_data", 32'(bus_data), 32'd0);
        end
    end

    initial begin
        logic [3:0] exp_g;
        logic       exp_p;
        int         order[5];
        order = '{0, 1, 2, 3, 0};
        rst   = 1'b1;
        req   = 4'b0000;
        wdata = 32'hD3C2B1A0;
        tick();
        tick();
        mon_en = 1'b1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_data", 32'(bus_data), 32'd0);
        check("rst_owner", 32'(owner_id), 32'd0);

        // Basic grant: lowest index at/after pointer 0.
        rst = 1'b0;
        req = 4'b0101;
        tick();
        check("first_gnt", 32'(gnt), 32'h1);
        check("first_owner", 32'(owner_id), 32'd0);
        check("first_data", 32'(bus_data), 32'(slice(0)));
        check("first_valid", 32'(bus_valid), 32'd1);

        // All requesting: 8-cycle tenures, preempt at each handover, order 0,1,2,3,0.
        req = 4'b0000;
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int c = 1; c <= 8; c++) begin
                exp_g = 4'b0001 << order[k];
`ifdef TRI_BUS_ARBITER_TURNAROUND_EN
                exp_p = 1'b0;
`else
                exp_p = (c == 1) && (k != 0);
`endif
                check($sformatf("rr_gnt_k%0d_c%0d", k, c), 32'(gnt), 32'(exp_g));
                check($sformatf("rr_pre_k%0d_c%0d", k, c), 32'(preempt), 32'(exp_p));
                if (c == 1) check($sformatf("rr_data_k%0d", k), 32'(bus_data), 32'(slice(order[k])));
                tick();
            end
`ifdef TRI_BUS_ARBITER_TURNAROUND_EN
            if (k != 4) begin
                check($sformatf("rr_turn_gnt_k%0d", k), 32'(gnt), 32'd0);
                check($sformatf("rr_turn_pre_k%0d", k), 32'(preempt), 32'd1);
                tick();
            end
`endif
        end

        // Lone requester keeps the bus past MAX_TENURE.
        req = 4'b0000;
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("solo_gnt_%0d", c), 32'(gnt), 32'h4);
            check($sformatf("solo_pre_%0d", c), 32'(preempt), 32'd0);
        end
        check("solo_data", 32'(bus_data), 32'(slice(2)));
        check("solo_owner", 32'(owner_id), 32'd2);

        // Owner drop with a waiter.
        req = 4'b0000;
        do_reset();
        req = 4'b0010;
        tick();
        check("drop_own1", 32'(gnt), 32'h2);
        tick();
        req = 4'b1010;
        tick();
        check("drop_wait", 32'(gnt), 32'h2);
        tick();
        check("drop_wait2", 32'(gnt), 32'h2);
        req = 4'b1000;
        tick();
`ifdef TRI_BUS_ARBITER_TURNAROUND_EN
        check("drop_turn", 32'(gnt), 32'd0);
        check("drop_turn_valid", 32'(bus_valid), 32'd0);
        tick();
`endif
        check("drop_new", 32'(gnt), 32'h8);
        check("drop_pre", 32'(preempt), 32'd0);
        check("drop_owner", 32'(owner_id), 32'd3);

        // Move the pointer, then reset mid-tenure and confirm search restarts at 0.
        req = 4'b0000;
        do_reset();
        req = 4'b0001;
        tick();
        check("ptr_own0", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("ptr_rel", 32'(gnt), 32'd0);
        req = 4'b1001;
        tick();
        check("ptr_own3", 32'(gnt), 32'h8);
        for (int c = 0; c < 4; c++) tick();
        check("mid_still3", 32'(gnt), 32'h8);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_pre", 32'(preempt), 32'd0);
        check("mid_rst_valid", 32'(bus_valid), 32'd0);
        check("mid_rst_data", 32'(bus_data), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h1);
        check("post_rst_data", 32'(bus_data), 32'(slice(0)));

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
